// File: rtl/gpio_bus_arbiter_if.sv
// rtl/gpio_bus_arbiter_if.sv - request/ack and GPIO bus signals shared by the two requesters and the arbiter
interface gpio_bus_arbiter_if #(
  parameter int DW = 32
);
  logic          m0_req;
  logic [1:0]    m0_a;
  logic          m0_we;
  logic [DW-1:0] m0_wd;
  logic          m0_ack;
  logic [DW-1:0] m0_rd;

  logic          m1_req;
  logic [1:0]    m1_a;
  logic          m1_we;
  logic [DW-1:0] m1_wd;
  logic          m1_ack;
  logic [DW-1:0] m1_rd;

  logic [1:0]    gp_a;
  logic          gp_we;
  logic [DW-1:0] gp_wd;
  logic [DW-1:0] gp_rd;

  logic          busy;
  logic          grant_id;

  // Arbiter side: takes requests, drives acks and the GPIO bus.
  modport slave (
    input  m0_req, m0_a, m0_we, m0_wd,
    output m0_ack, m0_rd,
    input  m1_req, m1_a, m1_we, m1_wd,
    output m1_ack, m1_rd,
    output gp_a, gp_we, gp_wd,
    input  gp_rd,
    output busy, grant_id
  );

  // Requester/peripheral side.
  modport master (
    output m0_req, m0_a, m0_we, m0_wd,
    input  m0_ack, m0_rd,
    output m1_req, m1_a, m1_we, m1_wd,
    input  m1_ack, m1_rd,
    input  gp_a, gp_we, gp_wd,
    output gp_rd,
    input  busy, grant_id
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - serialises m0/m1 accesses onto the GPIO register bus
// IDLE selects and latches a winner, ADDR drives the access, DATA acks the winner.
module gpio_bus_arbiter #(
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  gpio_bus_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    r_state;
  logic          r_win;
  logic          r_rr_last;
  logic [1:0]    r_a;
  logic          r_we;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_m0_rd;
  logic [DW-1:0] r_m1_rd;

  logic          w_any;
  logic          w_win;
  logic          w_active;

  // Round-robin hands a contested slot to whichever master did not win last.
  always_comb begin
    w_any = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      w_win = (FIXED_PRI != 0) ? 1'b0 : ~r_rr_last;
    end else begin
      w_win = bus.m1_req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_win     <= 1'b0;
      r_rr_last <= 1'b1;
      r_a       <= 2'd0;
      r_we      <= 1'b0;
      r_wd      <= '0;
      r_m0_rd   <= '0;
      r_m1_rd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            r_rr_last <= w_win;
            r_a       <= w_win ? bus.m1_a  : bus.m0_a;
            r_we      <= w_win ? bus.m1_we : bus.m0_we;
            r_wd      <= w_win ? bus.m1_wd : bus.m0_wd;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          // gp_rd follows gp_a combinationally, so it is settled by the end of ADDR.
          if (!r_we) begin
            if (r_win) begin
              r_m1_rd <= bus.gp_rd;
            end else begin
              r_m0_rd <= bus.gp_rd;
            end
          end
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_active     = (r_state == S_ADDR) || (r_state == S_DATA);

  assign bus.busy     = w_active;
  assign bus.grant_id = r_win;
  assign bus.gp_a     = w_active ? r_a  : 2'd0;
  assign bus.gp_wd    = w_active ? r_wd : '0;
  assign bus.gp_we    = (r_state == S_ADDR) && r_we;

  assign bus.m0_ack   = (r_state == S_DATA) && !r_win;
  assign bus.m1_ack   = (r_state == S_DATA) &&  r_win;
  assign bus.m0_rd    = r_m0_rd;
  assign bus.m1_rd    = r_m1_rd;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb/tb_gpio_bus_arbiter.sv - directed vector bench for gpio_bus_arbiter in round-robin and fixed-priority builds
module tb_gpio_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_bus_arbiter_if #(.DW(32)) bi0 ();
  gpio_bus_arbiter_if #(.DW(32)) bi1 ();

  gpio_bus_arbiter #(.DW(32), .FIXED_PRI(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bi0));
  gpio_bus_arbiter #(.DW(32), .FIXED_PRI(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bi1));

  function automatic logic [31:0] rd_of(input logic [1:0] a);
    case (a)
      2'd0:    rd_of = 32'hA0A0A0A0;
      2'd1:    rd_of = 32'h12345678;
      2'd2:    rd_of = 32'hCAFEF00D;
      default: rd_of = 32'h0BADC0DE;
    endcase
  endfunction

  assign bi0.gp_rd = rd_of(bi0.gp_a);
  assign bi1.gp_rd = rd_of(bi1.gp_a);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive0(input logic m0r, input logic m0we, input logic [1:0] m0a, input logic [31:0] m0wd,
                        input logic m1r, input logic m1we, input logic [1:0] m1a, input logic [31:0] m1wd);
    bi0.m0_req = m0r; bi0.m0_we = m0we; bi0.m0_a = m0a; bi0.m0_wd = m0wd;
    bi0.m1_req = m1r; bi0.m1_we = m1we; bi0.m1_a = m1a; bi0.m1_wd = m1wd;
  endtask

  task automatic drive1(input logic m0r, input logic m0we, input logic [1:0] m0a, input logic [31:0] m0wd,
                        input logic m1r, input logic m1we, input logic [1:0] m1a, input logic [31:0] m1wd);
    bi1.m0_req = m0r; bi1.m0_we = m0we; bi1.m0_a = m0a; bi1.m0_wd = m0wd;
    bi1.m1_req = m1r; bi1.m1_we = m1we; bi1.m1_a = m1a; bi1.m1_wd = m1wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        m0r, m0we; logic [1:0] m0a; logic [31:0] m0wd;
    logic        m1r, m1we; logic [1:0] m1a; logic [31:0] m1wd;
    logic        busy, gpwe; logic [1:0] gpa; logic [31:0] gpwd;
    logic        ack0, ack1, gid;
    logic [31:0] rd0, rd1;
  } vec_t;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] R1 = 32'h12345678;
  localparam logic [31:0] R3 = 32'h0BADC0DE;
  localparam logic [31:0] W5 = 32'h5A5A5A5A;
  localparam logic [31:0] W1 = 32'h11111111;
  localparam logic [31:0] W2 = 32'h22222222;

  vec_t tbl [18];

  int ev_m [8];
  int ev_c [8];
  int n_ev;
  int both;
  int a0;
  int a1;
  int got;

  initial begin
    drive0(1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    drive1(1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);

    // rst | m0 req/we/a/wd | m1 req/we/a/wd | busy gp_we gp_a gp_wd | ack0 ack1 gid | rd0 rd1
    tbl[0]  = '{1'b1, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b0, Z,Z};
    tbl[1]  = '{1'b1, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b0, Z,Z};
    tbl[2]  = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b0, Z,Z};
    tbl[3]  = '{1'b0, 1'b1,1'b1,2'd2,DB, 1'b0,1'b0,2'd0,Z,  1'b1,1'b1,2'd2,DB, 1'b0,1'b0,1'b0, Z,Z};
    tbl[4]  = '{1'b0, 1'b1,1'b1,2'd2,DB, 1'b0,1'b0,2'd0,Z,  1'b1,1'b0,2'd2,DB, 1'b1,1'b0,1'b0, Z,Z};
    tbl[5]  = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b0, Z,Z};
    tbl[6]  = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b1,1'b0,2'd1,W5, 1'b1,1'b0,2'd1,W5, 1'b0,1'b0,1'b1, Z,Z};
    tbl[7]  = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b1,1'b0,2'd1,W5, 1'b1,1'b0,2'd1,W5, 1'b0,1'b1,1'b1, Z,R1};
    tbl[8]  = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b1, Z,R1};
    tbl[9]  = '{1'b0, 1'b1,1'b0,2'd3,Z,  1'b0,1'b0,2'd0,Z,  1'b1,1'b0,2'd3,Z,  1'b0,1'b0,1'b0, Z,R1};
    tbl[10] = '{1'b0, 1'b1,1'b0,2'd3,Z,  1'b0,1'b0,2'd0,Z,  1'b1,1'b0,2'd3,Z,  1'b1,1'b0,1'b0, R3,R1};
    tbl[11] = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b0, R3,R1};
    // m0 won last, so the contested slot goes to m1 and m0 is served next pass
    tbl[12] = '{1'b0, 1'b1,1'b1,2'd0,W1, 1'b1,1'b1,2'd3,W2, 1'b1,1'b1,2'd3,W2, 1'b0,1'b0,1'b1, R3,R1};
    tbl[13] = '{1'b0, 1'b1,1'b1,2'd0,W1, 1'b1,1'b1,2'd3,W2, 1'b1,1'b0,2'd3,W2, 1'b0,1'b1,1'b1, R3,R1};
    tbl[14] = '{1'b0, 1'b1,1'b1,2'd0,W1, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b1, R3,R1};
    tbl[15] = '{1'b0, 1'b1,1'b1,2'd0,W1, 1'b0,1'b0,2'd0,Z,  1'b1,1'b1,2'd0,W1, 1'b0,1'b0,1'b0, R3,R1};
    tbl[16] = '{1'b0, 1'b1,1'b1,2'd0,W1, 1'b0,1'b0,2'd0,Z,  1'b1,1'b0,2'd0,W1, 1'b1,1'b0,1'b0, R3,R1};
    tbl[17] = '{1'b0, 1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,2'd0,Z,  1'b0,1'b0,1'b0, R3,R1};

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst;
      drive0(tbl[i].m0r, tbl[i].m0we, tbl[i].m0a, tbl[i].m0wd,
             tbl[i].m1r, tbl[i].m1we, tbl[i].m1a, tbl[i].m1wd);
      tick();
      chk($sformatf("v%0d_busy", i),  {31'd0, bi0.busy},     {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_gp_we", i), {31'd0, bi0.gp_we},    {31'd0, tbl[i].gpwe});
      chk($sformatf("v%0d_gp_a", i),  {30'd0, bi0.gp_a},     {30'd0, tbl[i].gpa});
      chk($sformatf("v%0d_gp_wd", i), bi0.gp_wd,             tbl[i].gpwd);
      chk($sformatf("v%0d_ack0", i),  {31'd0, bi0.m0_ack},   {31'd0, tbl[i].ack0});
      chk($sformatf("v%0d_ack1", i),  {31'd0, bi0.m1_ack},   {31'd0, tbl[i].ack1});
      chk($sformatf("v%0d_gid", i),   {31'd0, bi0.grant_id}, {31'd0, tbl[i].gid});
      chk($sformatf("v%0d_rd0", i),   bi0.m0_rd,             tbl[i].rd0);
      chk($sformatf("v%0d_rd1", i),   bi0.m1_rd,             tbl[i].rd1);
    end

    // Fixed priority: m0 monopolises the bus while it keeps requesting.
    drive1(1'b1, 1'b0, 2'd1, Z, 1'b1, 1'b0, 2'd3, Z);
    a0 = 0; a1 = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bi1.m0_ack) a0++;
      if (bi1.m1_ack) a1++;
    end
    chk("fp_m0_acks", a0, 4);
    chk("fp_m1_acks", a1, 0);
    drive1(1'b0, 1'b0, 2'd0, Z, 1'b1, 1'b0, 2'd3, Z);
    got = 0; a0 = 0;
    for (int c = 1; c <= 6 && got == 0; c++) begin
      tick();
      if (bi1.m0_ack) a0++;
      if (bi1.m1_ack) got = c;
    end
    chk("fp_m1_served_cycle", got, 2);
    chk("fp_m0_acks_after_drop", a0, 0);
    chk("fp_m1_rd", bi1.m1_rd, rd_of(2'd3));
    drive1(1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();

    // Round-robin from reset: m0 first, then strict alternation every 3 cycles.
    rst = 1'b1;
    drive0(1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    tick();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 2'd0, Z, 1'b1, 1'b0, 2'd2, Z);
    n_ev = 0; both = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (bi0.m0_ack && bi0.m1_ack) both++;
      if ((bi0.m0_ack || bi0.m1_ack) && n_ev < 8) begin
        ev_m[n_ev] = bi0.m1_ack ? 1 : 0;
        ev_c[n_ev] = c;
        n_ev++;
      end
    end
    chk("rr_ack_count", n_ev, 5);
    chk("rr_both_acks", both, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_ack%0d_master", k), ev_m[k], k % 2);
      chk($sformatf("rr_ack%0d_cycle", k), ev_c[k], 2 + 3 * k);
    end
    chk("rr_m0_rd", bi0.m0_rd, rd_of(2'd0));
    chk("rr_m1_rd", bi0.m1_rd, rd_of(2'd2));
    drive0(1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();

    // Reset while an m1 write is in ADDR aborts it; the re-issued contest goes to m0.
    drive0(1'b0, 1'b0, 2'd0, Z, 1'b1, 1'b1, 2'd1, 32'h33333333);
    tick();
    chk("rst_pre_gp_we", {31'd0, bi0.gp_we}, 32'd1);
    chk("rst_pre_gid", {31'd0, bi0.grant_id}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_busy", {31'd0, bi0.busy}, 32'd0);
    chk("rst_gp_we", {31'd0, bi0.gp_we}, 32'd0);
    chk("rst_m1_ack", {31'd0, bi0.m1_ack}, 32'd0);
    chk("rst_gid", {31'd0, bi0.grant_id}, 32'd0);
    chk("rst_rd0", bi0.m0_rd, Z);
    rst = 1'b0;
    drive0(1'b1, 1'b0, 2'd2, Z, 1'b1, 1'b1, 2'd1, 32'h33333333);
    tick();
    chk("rerq_gid", {31'd0, bi0.grant_id}, 32'd0);
    chk("rerq_gp_a", {30'd0, bi0.gp_a}, 32'd2);
    chk("rerq_gp_we", {31'd0, bi0.gp_we}, 32'd0);
    tick();
    chk("rerq_m0_ack", {31'd0, bi0.m0_ack}, 32'd1);
    chk("rerq_m1_ack", {31'd0, bi0.m1_ack}, 32'd0);
    chk("rerq_m0_rd", bi0.m0_rd, rd_of(2'd2));
    drive0(1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
